// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, the
// per-cycle event classes and the instruction register-field positions.
package hazard_pkg;

  localparam int REG_W = 3;
  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_LDUSE = 3'd1,
    ST_DWAIT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HALT,
    EV_FREEZE,
    EV_BRANCH,
    EV_LDUSE,
    EV_IMEM,
    EV_HALTED
  } event_t;

  // Priority decode of the winning event. A branch seen in FLUSH is a bubble,
  // and a load-use seen in LDUSE/FLUSH is already covered by forwarding.
  function automatic event_t pick_event(input state_t s, input logic halt,
                                        input logic dmem, input logic br,
                                        input logic lu, input logic imem);
    if (s == ST_HALT)             return EV_HALTED;
    if (s == ST_DWAIT && dmem)    return EV_FREEZE;
    if (halt)                     return EV_HALT;
    if (dmem)                     return EV_FREEZE;
    if (br && s != ST_FLUSH)      return EV_BRANCH;
    if (lu && s != ST_LDUSE && s != ST_FLUSH) return EV_LDUSE;
    if (imem)                     return EV_IMEM;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: flags when the load in EX writes a
// register that the instruction in decode actually reads.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic [REG_W-1:0] i_dst,
  input  logic             i_uses_rs,
  input  logic             i_uses_rt,
  input  logic             i_mem_read,
  output logic             o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = i_uses_rs && (i_dst == i_rs);
  assign w_rt_hit   = i_uses_rt && (i_dst == i_rt);
  assign o_load_use = i_mem_read && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle advance/hold/flush decisions for
// the 5-stage pipeline, plus saturating stall and redirect counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int FLUSH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ifid_Instr,
  input  logic               ifid_UsesRs,
  input  logic               ifid_UsesRt,
  input  logic               idex_MemRead,
  input  logic [REG_W-1:0]   idex_RegD,
  input  logic               branch_taken,
  input  logic               imem_busy,
  input  logic               dmem_busy,
  input  logic               halt_req,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_en,
  output logic               idex_flush,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               halted,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [FLUSH_W-1:0] flush_count
);

  state_t               r_state;
  state_t               w_state_next;
  event_t               w_evt;
  logic                 w_load_use;
  logic [CNT_W-1:0]     r_stall;
  logic [FLUSH_W-1:0]   r_flush;
  logic                 w_unused_instr_bits;

  assign w_unused_instr_bits = ^{ifid_Instr[15:11], ifid_Instr[4:0]};

  load_use_detect u_load_use_detect (
    .i_rs       (ifid_Instr[RS_HI:RS_LO]),
    .i_rt       (ifid_Instr[RT_HI:RT_LO]),
    .i_dst      (idex_RegD),
    .i_uses_rs  (ifid_UsesRs),
    .i_uses_rt  (ifid_UsesRt),
    .i_mem_read (idex_MemRead),
    .o_load_use (w_load_use)
  );

  assign w_evt = pick_event(r_state, halt_req, dmem_busy, branch_taken,
                            w_load_use, imem_busy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = ST_RUN;
    case (w_evt)
      EV_HALT, EV_HALTED: w_state_next = ST_HALT;
      EV_FREEZE:          w_state_next = ST_DWAIT;
      EV_BRANCH:          w_state_next = ST_FLUSH;
      EV_LDUSE:           w_state_next = ST_LDUSE;
      default:            w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    halted     = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    end else begin
      case (w_evt)
        EV_HALT, EV_FREEZE: {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        EV_HALTED: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          halted = 1'b1;
        end
        EV_BRANCH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        EV_LDUSE: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        EV_IMEM: begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
        default: ;
      endcase
      // Synchronous imem still returns the wrong-path fetch one cycle later.
      if (r_state == ST_FLUSH) ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (!pc_en && r_state != ST_HALT && r_stall != '1) r_stall <= r_stall + 1'b1;
      if (w_evt == EV_BRANCH && r_flush != '1)          r_flush <= r_flush + 1'b1;
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int CNT_W   = 16;
  localparam int FLUSH_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [15:0]        ifid_Instr;
  logic               ifid_UsesRs, ifid_UsesRt, idex_MemRead;
  logic [2:0]         idex_RegD;
  logic               branch_taken, imem_busy, dmem_busy, halt_req;
  logic               pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic               exmem_en, memwb_en, halted;
  logic [2:0]         state;
  logic [CNT_W-1:0]   stall_cycles;
  logic [FLUSH_W-1:0] flush_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_W(FLUSH_W)) dut (
    .clk(clk), .rst(rst),
    .ifid_Instr(ifid_Instr), .ifid_UsesRs(ifid_UsesRs), .ifid_UsesRt(ifid_UsesRt),
    .idex_MemRead(idex_MemRead), .idex_RegD(idex_RegD),
    .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .halted(halted), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Reference model: mode number (0 RUN,1 LDUSE,2 DWAIT,3 FLUSH,4 HALT) and counters.
  int          m_state = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  int          n_state;
  int unsigned n_stall, n_flush;

  always @(negedge clk) begin
    logic lu, frozen, br_win, lu_win;
    logic e_pc, e_ifen, e_iffl, e_iden, e_idfl, e_exen, e_mwen, e_halt;
    logic [7:0] exp_v, got_v;
    cycle++;
    {e_pc, e_ifen, e_iden, e_exen, e_mwen} = 5'b11111;
    {e_iffl, e_idfl, e_halt} = 3'b000;
    n_state = 0; n_stall = m_stall; n_flush = m_flush;
    if (rst) begin
      {e_pc, e_ifen, e_iden, e_exen, e_mwen} = 5'b00000;
      n_stall = 0; n_flush = 0;
    end else begin
      lu = idex_MemRead && ((ifid_UsesRs && idex_RegD == ifid_Instr[10:8]) ||
                            (ifid_UsesRt && idex_RegD == ifid_Instr[7:5]));
      frozen = 0; br_win = 0; lu_win = 0;
      if (m_state == 4) begin
        frozen = 1; e_halt = 1; n_state = 4;
      end else if (m_state == 2 && dmem_busy) begin
        frozen = 1; n_state = 2;
      end else if (halt_req) begin
        frozen = 1; n_state = 4;
      end else if (dmem_busy) begin
        frozen = 1; n_state = 2;
      end else if (branch_taken && m_state != 3) begin
        br_win = 1; n_state = 3;
      end else if (lu && m_state == 0 || lu && m_state == 2) begin
        lu_win = 1; n_state = 1;
      end else if (imem_busy) begin
        e_pc = 0; e_iffl = 1;
      end
      if (frozen) {e_pc, e_ifen, e_iden, e_exen, e_mwen} = 5'b00000;
      if (br_win) begin e_iffl = 1; e_idfl = 1; end
      if (lu_win) begin e_pc = 0; e_ifen = 0; e_idfl = 1; end
      if (m_state == 3) e_iffl = 1;
      if (!e_pc && m_state != 4 && m_stall < (2**CNT_W) - 1) n_stall = m_stall + 1;
      if (br_win && m_flush < (2**FLUSH_W) - 1) n_flush = m_flush + 1;
    end
    exp_v = {e_pc, e_ifen, e_iffl, e_iden, e_idfl, e_exen, e_mwen, e_halt};
    got_v = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted};
    checks += 4;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL ctl_vec cycle %0d got %b expected %b", cycle, got_v, exp_v);
    end
    if (state !== 3'(rst ? 0 : m_state)) begin
      errors++;
      $display("FAIL state cycle %0d got %0d expected %0d", cycle, state, rst ? 0 : m_state);
    end
    if (stall_cycles !== CNT_W'(rst ? 0 : m_stall)) begin
      errors++;
      $display("FAIL stall_cycles cycle %0d got %0d expected %0d", cycle, stall_cycles, m_stall);
    end
    if (flush_count !== FLUSH_W'(rst ? 0 : m_flush)) begin
      errors++;
      $display("FAIL flush_count cycle %0d got %0d expected %0d", cycle, flush_count, m_flush);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      m_state <= n_state; m_stall <= n_stall; m_flush <= n_flush;
    end
  end

  task automatic lit(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_Instr = '0; ifid_UsesRs = 0; ifid_UsesRt = 0; idex_MemRead = 0;
    idex_RegD = '0; branch_taken = 0; imem_busy = 0; dmem_busy = 0; halt_req = 0;
  endtask

  task automatic reset_pulse();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    lit("rst_pc_en", pc_en, 0);
    lit("rst_memwb_en", memwb_en, 0);
    lit("rst_state", state, 0);
    lit("rst_stall", stall_cycles, 0);
    lit("rst_halted", halted, 0);
    rst = 0; #1;
    lit("idle_pc_en", pc_en, 1);
    lit("idle_ifid_flush", ifid_flush, 0);
    step();

    // Load-use on Rs=3
    ifid_Instr = 16'h0300; ifid_UsesRs = 1; idex_MemRead = 1; idex_RegD = 3; #1;
    lit("lu_pc_en", pc_en, 0);
    lit("lu_ifid_en", ifid_en, 0);
    lit("lu_idex_flush", idex_flush, 1);
    lit("lu_idex_en", idex_en, 1);
    step(); #1;
    lit("lu2_state", state, 1);
    lit("lu2_pc_en", pc_en, 1);
    lit("lu2_idex_flush", idex_flush, 0);
    lit("lu2_stall", stall_cycles, 1);
    idle(); step(); #1;
    lit("lu3_state", state, 0);

    // Matching Rt field that the instruction does not read
    ifid_Instr = 16'h0060; ifid_UsesRs = 1; idex_MemRead = 1; idex_RegD = 3; #1;
    lit("rt_unused_pc_en", pc_en, 1);
    lit("rt_unused_idex_flush", idex_flush, 0);
    step(); #1;
    lit("rt_unused_state", state, 0);
    idle();

    // Taken branch
    branch_taken = 1; #1;
    lit("br_pc_en", pc_en, 1);
    lit("br_ifid_flush", ifid_flush, 1);
    lit("br_idex_flush", idex_flush, 1);
    step(); branch_taken = 0; #1;
    lit("br1_state", state, 3);
    lit("br1_ifid_flush", ifid_flush, 1);
    lit("br1_idex_flush", idex_flush, 0);
    lit("br1_flush_count", flush_count, 1);
    step(); #1;
    lit("br2_state", state, 0);
    lit("br2_ifid_flush", ifid_flush, 0);

    // Data memory wait with a pending branch
    dmem_busy = 1; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      lit("dw_pc_en", pc_en, 0);
      lit("dw_memwb_en", memwb_en, 0);
      lit("dw_ifid_flush", ifid_flush, 0);
      step();
    end
    dmem_busy = 0; #1;
    lit("dw_rel_state", state, 2);
    lit("dw_rel_pc_en", pc_en, 1);
    lit("dw_rel_idex_flush", idex_flush, 1);
    lit("dw_rel_stall", stall_cycles, 4);
    step(); branch_taken = 0; #1;
    lit("dw_flush_state", state, 3);
    lit("dw_flush_count", flush_count, 2);
    step();

    // HALT with a simultaneous load-use
    halt_req = 1; ifid_Instr = 16'h0300; ifid_UsesRs = 1; idex_MemRead = 1; idex_RegD = 3; #1;
    lit("halt_pc_en", pc_en, 0);
    lit("halt_exmem_en", exmem_en, 0);
    lit("halt_idex_flush", idex_flush, 0);
    step(); idle(); #1;
    lit("halted", halted, 1);
    lit("halt_state", state, 4);
    step(); step(); #1;
    lit("halt_persist", halted, 1);
    lit("halt_stall", stall_cycles, 5);

    // Asynchronous reset mid-cycle
    @(negedge clk); #2;
    rst = 1; #1;
    lit("arst_state", state, 0);
    lit("arst_stall", stall_cycles, 0);
    lit("arst_flush", flush_count, 0);
    lit("arst_halted", halted, 0);
    step(); rst = 0; step();

    // Randomized traffic in reset-separated chunks
    for (int c = 0; c < 10; c++) begin
      reset_pulse();
      for (int i = 0; i < 300; i++) begin
        ifid_Instr   = 16'($urandom);
        ifid_UsesRs  = 1'($urandom);
        ifid_UsesRt  = 1'($urandom);
        idex_MemRead = 1'($urandom);
        idex_RegD    = 3'($urandom);
        branch_taken = ($urandom_range(0, 4) == 0);
        imem_busy    = ($urandom_range(0, 4) == 0);
        dmem_busy    = ($urandom_range(0, 5) == 0);
        halt_req     = ($urandom_range(0, 199) == 0);
        step();
      end
    end

    // Redirect counter saturation
    idle(); reset_pulse();
    branch_taken = 1;
    repeat (600) step();
    idle(); #1;
    lit("flush_sat", flush_count, 8'hFF);

    // Stall counter saturation
    reset_pulse();
    imem_busy = 1;
    repeat ((2**CNT_W) + 5) step();
    #1;
    lit("stall_sat", stall_cycles, 16'hFFFF);
    idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
